// File: rtl/spio_link_tx_arbiter.sv
// Round-robin, whole-packet arbiter that lets NUM_PORTS packet sources share one
// SpiNNaker link sender through a single registered output slot.
`ifndef PKT_BITS
`define PKT_BITS 72
`endif

module spio_link_tx_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int PTR_BITS  = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS-1:0]           port_en,
    input  logic [NUM_PORTS*`PKT_BITS-1:0] in_data,
    input  logic [NUM_PORTS-1:0]           in_vld,
    output logic [NUM_PORTS-1:0]           in_rdy,
    output logic [`PKT_BITS-1:0]           out_data,
    input  logic                           out_rdy,
    output logic                           out_vld,
    output logic [PTR_BITS-1:0]            grant_port,
    output logic                           ctr_pkt
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [`PKT_BITS-1:0]   out_data_q, out_data_d;
    logic                   out_vld_q, out_vld_d;
    logic [PTR_BITS-1:0]    grant_q, grant_d;
    logic                   ctr_q, ctr_d;

    logic [NUM_PORTS-1:0]   req;
    logic [NUM_PORTS-1:0]   gnt;
    logic [`PKT_BITS-1:0]   in_pkt [NUM_PORTS];
    logic                   win_found;
    logic [PTR_BITS-1:0]    win_idx;
    int                     cand;

    assign req = in_vld & port_en;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign in_pkt[gi] = in_data[gi*`PKT_BITS +: `PKT_BITS];
            assign gnt[gi]    = win_found && (win_idx == PTR_BITS'(gi));
        end
    endgenerate

    // Search starts one past the last winner, so the last winner has lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = (int'(grant_q) + k) % NUM_PORTS;
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = PTR_BITS'(cand);
            end
        end
    end

    assign in_rdy = (state_q == IDLE && !rst) ? gnt : '0;

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_vld_d  = out_vld_q;
        grant_d    = grant_q;
        ctr_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d    = BUSY;
                    out_data_d = in_pkt[win_idx];
                    out_vld_d  = 1'b1;
                    grant_d    = win_idx;
                end
            end
            BUSY: begin
                if (out_rdy) begin
                    state_d   = IDLE;
                    out_vld_d = 1'b0;
                    ctr_d     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            out_data_q <= '0;
            out_vld_q  <= 1'b0;
            grant_q    <= PTR_BITS'(NUM_PORTS - 1);
            ctr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_vld_q  <= out_vld_d;
            grant_q    <= grant_d;
            ctr_q      <= ctr_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_vld    = out_vld_q;
    assign grant_port = grant_q;
    assign ctr_pkt    = ctr_q;

endmodule

// File: tb/tb_spio_link_tx_arbiter.sv
// Directed bench for spio_link_tx_arbiter: per-cycle behavioural model, end-to-end
// receiver scoreboard and literal expectations for each scenario.
`ifndef PKT_BITS
`define PKT_BITS 72
`endif

module tb_spio_link_tx_arbiter;

    localparam int N = 4;
    localparam int W = `PKT_BITS;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     port_en;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_vld;
    logic [N-1:0]     in_rdy;
    logic [W-1:0]     out_data;
    logic             out_vld;
    logic             out_rdy;
    logic [1:0]       grant_port;
    logic             ctr_pkt;
    logic [W-1:0]     pkt [N];

    int vectors = 0;
    int miscompares = 0;

    assign in_data = {pkt[3], pkt[2], pkt[1], pkt[0]};

    spio_link_tx_arbiter #(.NUM_PORTS(N), .PTR_BITS(2)) dut (
        .clk(clk), .rst(rst), .port_en(port_en), .in_data(in_data),
        .in_vld(in_vld), .in_rdy(in_rdy), .out_data(out_data), .out_rdy(out_rdy),
        .out_vld(out_vld), .grant_port(grant_port), .ctr_pkt(ctr_pkt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin rule: first requester strictly after the last grant, wrapping.
    function automatic int pick(input logic [N-1:0] r, input int g);
        for (int k = 1; k <= N; k++)
            if (r[(g + k) % N]) return (g + k) % N;
        return -1;
    endfunction

    // Model: held packet slot, pointer, pulse flag, and queue of packets owed to the link.
    bit           model_ok = 0;
    bit           m_busy;
    int           m_grant;
    logic [W-1:0] m_data;
    bit           m_ctr;
    logic [W-1:0] exp_q [$];
    int           grant_log [$];
    int           ctr_cnt = 0;
    int           mw;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_grant = N - 1; m_data = '0; m_ctr = 0;
            exp_q.delete();
            model_ok = 1;
        end else if (model_ok) begin
            m_ctr = 0;
            if (!m_busy) begin
                mw = pick(in_vld & port_en, m_grant);
                if (mw >= 0) begin
                    m_busy = 1; m_data = pkt[mw]; m_grant = mw;
                    exp_q.push_back(pkt[mw]);
                end
            end else if (out_rdy) begin
                m_busy = 0; m_ctr = 1;
            end
        end
    end

    logic [N-1:0] exp_rdy;
    int           cw;

    always @(negedge clk) begin
        if (model_ok) begin
            exp_rdy = '0;
            if (!rst && !m_busy) begin
                cw = pick(in_vld & port_en, m_grant);
                if (cw >= 0) exp_rdy[cw] = 1'b1;
            end
            chk("in_rdy", W'(in_rdy), W'(exp_rdy));
            chk("out_vld", W'(out_vld), W'(m_busy));
            chk("grant_port", W'(grant_port), W'(m_grant));
            chk("ctr_pkt", W'(ctr_pkt), W'(m_ctr));
            if (m_busy) chk("out_data", out_data, m_data);
            vectors++;
            assert ($onehot0(in_rdy)) else begin
                miscompares++;
                $display("FAIL onehot0_in_rdy: got %b required at most one bit", in_rdy);
            end
            for (int i = 0; i < N; i++) if (in_rdy[i]) grant_log.push_back(i);
            if (ctr_pkt) ctr_cnt++;
            // Link receiver: a transfer happens on the coming edge.
            if (out_vld && out_rdy && !rst) begin
                if (exp_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL sb_unexpected: got %0h required no packet", out_data);
                end else begin
                    chk("sb_data", out_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    int got;
    int n2;

    initial begin
        for (int i = 0; i < N; i++) pkt[i] = {8'(8'hA0 + i), 32'hC0DE_0000 + 32'(i), 32'h5A5A_0000 + 32'(i * 17)};
        rst = 1; port_en = 4'hF; in_vld = 4'hF; out_rdy = 0;

        // T1 reset
        tick(); tick();
        chk("t1_grant", W'(grant_port), W'(3));
        chk("t1_out_vld", W'(out_vld), W'(0));
        chk("t1_in_rdy_rst", W'(in_rdy), W'(0));
        grant_log.delete(); ctr_cnt = 0;
        out_rdy = 1;
        rst = 0;
        #1;
        chk("t1_in_rdy_first", W'(in_rdy), W'(4'b0001));

        // T2 round robin
        for (int c = 0; c < 12; c++) begin
            tick();
            for (int i = 0; i < N; i++) pkt[i] = W'({$urandom(), $urandom(), $urandom()});
        end
        in_vld = 4'h0;
        tick(); tick(); tick();
        chk("t2_accepts", W'(grant_log.size()), W'(6));
        if (grant_log.size() == 6) begin
            chk("t2_g0", W'(grant_log[0]), W'(0));
            chk("t2_g1", W'(grant_log[1]), W'(1));
            chk("t2_g2", W'(grant_log[2]), W'(2));
            chk("t2_g3", W'(grant_log[3]), W'(3));
            chk("t2_g4", W'(grant_log[4]), W'(0));
            chk("t2_g5", W'(grant_log[5]), W'(1));
        end
        chk("t2_ctr_pulses", W'(ctr_cnt), W'(6));

        // T3 backpressure
        pkt[2] = 72'h0123456789ABCDEF02;
        in_vld = 4'b0100; out_rdy = 0;
        tick();
        in_vld = 4'hF;
        ctr_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            chk("t3_data", out_data, 72'h0123456789ABCDEF02);
            chk("t3_vld", W'(out_vld), W'(1));
            chk("t3_in_rdy", W'(in_rdy), W'(0));
            tick();
        end
        chk("t3_grant", W'(grant_port), W'(2));
        in_vld = 4'h0; out_rdy = 1;
        tick(); tick(); tick();
        chk("t3_ctr", W'(ctr_cnt), W'(1));

        // T4 mask
        port_en = 4'b1011; in_vld = 4'hF; grant_log.delete();
        for (int c = 0; c < 8; c++) tick();
        n2 = 0;
        foreach (grant_log[i]) if (grant_log[i] == 2) n2++;
        chk("t4_no_port2", W'(n2), W'(0));
        chk("t4_some_grants", W'(grant_log.size() >= 3), W'(1));
        got = 0;
        for (int c = 0; c < 12 && got == 0; c++) begin
            if (in_rdy == 4'b0010) begin
                out_rdy = 0; got = 1;
            end
            tick();
        end
        chk("t4_busy_p1", W'(got), W'(1));
        chk("t4_grant1", W'(grant_port), W'(1));
        port_en = 4'hF;
        tick(); tick();
        out_rdy = 1; grant_log.delete();
        for (int c = 0; c < 4; c++) tick();
        if (grant_log.size() == 0) chk("t4_next_grant_seen", W'(0), W'(1));
        else chk("t4_next_is_2", W'(grant_log[0]), W'(2));

        // T5 sparse wrap
        in_vld = 4'h0;
        tick(); tick(); tick();
        grant_log.delete();
        in_vld = 4'b1000; tick();
        in_vld = 4'b0000; tick(); tick();
        in_vld = 4'b0001; tick();
        in_vld = 4'b0000; tick(); tick();
        chk("t5_grant0", W'(grant_port), W'(0));
        in_vld = 4'b1001; tick();
        in_vld = 4'b0000;
        chk("t5_count", W'(grant_log.size()), W'(3));
        if (grant_log.size() == 3) begin
            chk("t5_first", W'(grant_log[0]), W'(3));
            chk("t5_second", W'(grant_log[1]), W'(0));
            chk("t5_third", W'(grant_log[2]), W'(3));
        end

        // T6 reset mid-packet
        in_vld = 4'b0001; out_rdy = 1;
        tick(); tick();
        in_vld = 4'b0000; out_rdy = 0;
        tick();
        chk("t6_busy", W'(out_vld), W'(1));
        chk("t6_grant0", W'(grant_port), W'(0));
        ctr_cnt = 0;
        rst = 1;
        tick();
        chk("t6_vld_cleared", W'(out_vld), W'(0));
        chk("t6_grant_reset", W'(grant_port), W'(3));
        chk("t6_rdy_in_rst", W'(in_rdy), W'(0));
        rst = 0; out_rdy = 1;
        tick(); tick();
        chk("t6_no_ctr", W'(ctr_cnt), W'(0));
        chk("sb_drained", W'(exp_q.size()), W'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
